// File: rtl/ha_pkg.sv
// Shared constants and types for the lane-parallel half adder.
package ha_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // One lane's arithmetic result; {cout, sum} reads as a + b.
  typedef struct packed {
    logic cout;
    logic sum;
  } lane_result_t;

endpackage

// File: rtl/ha_cell.sv
// Single-bit combinational half adder: the arithmetic cell behind every lane.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

// File: rtl/half_adder.sv
// Lane-parallel half adder with optional output registers and a valid flag.
module half_adder
  import ha_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic             valid_o
);

  lane_result_t [WIDTH-1:0] lane_res;
  logic [WIDTH-1:0]         sum_comb;
  logic [WIDTH-1:0]         cout_comb;

  // Lanes never interact, so each one is a standalone cell.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .sum  (lane_res[i].sum),
      .cout (lane_res[i].cout)
    );
    assign sum_comb[i]  = lane_res[i].sum;
    assign cout_comb[i] = lane_res[i].cout;
  end

  if (REGISTERED) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] cout_q;
    logic             valid_q;

    // Results load only on qualified cycles; valid drops whenever en_i is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        cout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= en_i;
        if (en_i) begin
          sum_q  <= sum_comb;
          cout_q <= cout_comb;
        end
      end
    end

    assign sum     = sum_q;
    assign cout    = cout_q;
    assign valid_o = valid_q;
  end else begin : g_comb
    // Clock and reset stay on the port list so both variants share one interface.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign sum     = sum_comb;
    assign cout    = cout_comb;
    assign valid_o = en_i;
  end

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: registered 1-lane and 4-lane instances plus a combinational one.
module tb_half_adder;

  logic       clk;
  logic       rst_n;

  logic       en1, a1, b1;
  logic       sum1, cout1, valid1;

  logic       en4;
  logic [3:0] a4, b4;
  logic [3:0] sum4, cout4;
  logic       valid4;

  logic       enc, ac, bc;
  logic       sumc, coutc, validc;

  int vectors;
  int miscompares;

  half_adder #(.WIDTH(1), .REGISTERED(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en1), .a(a1), .b(b1),
    .sum(sum1), .cout(cout1), .valid_o(valid1)
  );

  half_adder #(.WIDTH(4), .REGISTERED(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .en_i(en4), .a(a4), .b(b4),
    .sum(sum4), .cout(cout4), .valid_o(valid4)
  );

  half_adder #(.WIDTH(1), .REGISTERED(1'b0)) dutc (
    .clk(clk), .rst_n(rst_n), .en_i(enc), .a(ac), .b(bc),
    .sum(sumc), .cout(coutc), .valid_o(validc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive the single-lane registered instance on a falling edge, away from capture.
  task automatic applyStimulus(input logic va, input logic vb, input logic ven);
    @(negedge clk);
    a1  = va;
    b1  = vb;
    en1 = ven;
  endtask

  // Expected single-lane results, hand-derived from the truth table.
  logic [1:0] vec_ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic       exp_sum [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       exp_cout[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    en4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    enc = 1'b0; ac = 1'b0; bc = 1'b0;

    // Reset held across edges with active operands.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_sum1",   {3'b0, sum1},   4'h0);
    checkOutput("rst_cout1",  {3'b0, cout1},  4'h0);
    checkOutput("rst_valid1", {3'b0, valid1}, 4'h0);
    checkOutput("rst_sum4",   sum4,           4'h0);
    checkOutput("rst_cout4",  cout4,          4'h0);
    checkOutput("rst_valid4", {3'b0, valid4}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en4   = 1'b0;

    $display("[TB] exhaustive single lane");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vec_ab[i][1], vec_ab[i][0], 1'b1);
      @(posedge clk);
      #1;
      checkOutput($sformatf("exh%0d_sum", i),   {3'b0, sum1},   {3'b0, exp_sum[i]});
      checkOutput($sformatf("exh%0d_cout", i),  {3'b0, cout1},  {3'b0, exp_cout[i]});
      checkOutput($sformatf("exh%0d_valid", i), {3'b0, valid1}, 4'h1);
    end

    $display("[TB] hold with en low");
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("hold_load_cout", {3'b0, cout1}, 4'h1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("hold_sum",   {3'b0, sum1},   4'h0);
    checkOutput("hold_cout",  {3'b0, cout1},  4'h1);
    checkOutput("hold_valid", {3'b0, valid1}, 4'h0);

    $display("[TB] multi-lane");
    @(negedge clk);
    en4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
    @(posedge clk);
    #1;
    checkOutput("ml0_sum",   sum4,           4'b0110);
    checkOutput("ml0_cout",  cout4,          4'b1000);
    checkOutput("ml0_valid", {3'b0, valid4}, 4'h1);
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'b0101;
    @(posedge clk);
    #1;
    checkOutput("ml1_sum",  sum4,  4'b1010);
    checkOutput("ml1_cout", cout4, 4'b0101);

    $display("[TB] combinational mode");
    for (int i = 0; i < 4; i++) begin
      ac  = vec_ab[i][1];
      bc  = vec_ab[i][0];
      enc = i[0];
      #1;
      checkOutput($sformatf("comb%0d_sum", i),   {3'b0, sumc},   {3'b0, exp_sum[i]});
      checkOutput($sformatf("comb%0d_cout", i),  {3'b0, coutc},  {3'b0, exp_cout[i]});
      checkOutput($sformatf("comb%0d_valid", i), {3'b0, validc}, {3'b0, i[0]});
    end

    $display("[TB] mid-stream reset");
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h3;
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_sum",  {3'b0, sum1}, 4'h1);
    checkOutput("pre_rst_sum4", sum4,         4'hC);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sum",   {3'b0, sum1},   4'h0);
    checkOutput("mid_rst_valid", {3'b0, valid1}, 4'h0);
    checkOutput("mid_rst_sum4",  sum4,           4'h0);
    checkOutput("mid_rst_cout4", cout4,          4'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resume_sum",   {3'b0, sum1},   4'h1);
    checkOutput("resume_cout",  {3'b0, cout1},  4'h0);
    checkOutput("resume_valid", {3'b0, valid1}, 4'h1);
    checkOutput("resume_cout4", cout4,          4'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
